// File: rtl/shift_deserializer.sv
// Reassembles FROM-bit words from a TO-bit serial lane (MS chunk first, last_i marks chunk 0)
// and presents them on a valid/ready output with sticky framing and overflow flags.
//
// state   | meaning
// SYNC    | waiting for last_i to align to a word boundary; data_i ignored
// COLLECT | shifting chunks into sr; cnt is the index of the chunk arriving now
module shift_deserializer #(
   parameter int FROM = 32,
   parameter int TO   = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [TO-1:0]   data_i,
   input  logic            last_i,
   input  logic            clr_i,
   output logic [FROM-1:0] data_o,
   output logic            valid_o,
   input  logic            ready_i,
   output logic            err_o,
   output logic            ovf_o
);

   localparam int N   = FROM / TO;
   localparam int CW  = ($clog2(N) > 1) ? $clog2(N) : 1;
   localparam int SRW = FROM - TO;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if ((FROM % TO) != 0 || N < 2) begin : g_bad_params
      $error("shift_deserializer: FROM must be a multiple of TO with FROM/TO >= 2");
   end

   typedef enum logic {SYNC, COLLECT} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [SRW-1:0]  sr;
   logic [FROM-1:0] word;
   logic            at_last;
   logic            complete;
   logic            frame_err;
   logic            load;
   logic            ovf_evt;

   always_comb begin
      word      = {sr, data_i};
      at_last   = (cnt == LAST);
      complete  = (state == COLLECT) && at_last && last_i;
      // early last or missing last: both are a mismatch between last_i and the chunk index
      frame_err = (state == COLLECT) && (last_i != at_last);
      load      = complete && (!valid_o || ready_i);
      ovf_evt   = complete && valid_o && !ready_i;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= SYNC;
         cnt     <= '0;
         sr      <= '0;
         data_o  <= '0;
         valid_o <= 1'b0;
         err_o   <= 1'b0;
         ovf_o   <= 1'b0;
      end else begin
         case (state)
            SYNC: begin
               if (last_i) begin
                  state <= COLLECT;
                  cnt   <= '0;
               end
            end
            COLLECT: begin
               if (at_last) begin
                  cnt <= '0;
                  if (!last_i) state <= SYNC;
               end else if (last_i) begin
                  cnt <= '0;
               end else begin
                  sr  <= word[SRW-1:0];
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state <= SYNC;
               cnt   <= '0;
            end
         endcase

         if (load) begin
            data_o  <= word;
            valid_o <= 1'b1;
         end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
         end

         if (frame_err)  err_o <= 1'b1;
         else if (clr_i) err_o <= 1'b0;

         if (ovf_evt)    ovf_o <= 1'b1;
         else if (clr_i) ovf_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer (FROM=32, TO=4): alignment, framing errors,
// overflow, back-pressure, sticky-flag clear and asynchronous reset mid-word.
module tb_shift_deserializer;

   logic        clk;
   logic        reset;
   logic [3:0]  data_i;
   logic        last_i;
   logic        clr_i;
   logic [31:0] data_o;
   logic        valid_o;
   logic        ready_i;
   logic        err_o;
   logic        ovf_o;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_cyc;

   shift_deserializer #(.FROM(32), .TO(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .data_i  (data_i),
      .last_i  (last_i),
      .clr_i   (clr_i),
      .data_o  (data_o),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .err_o   (err_o),
      .ovf_o   (ovf_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // inputs change 1 time unit after the rising edge; outputs sampled at the same point
   task automatic drive_chunk(input logic [3:0] d, input logic l);
      data_i = d;
      last_i = l;
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [31:0] w, input logic [31:0] exp_d,
                            input logic first_v, input logic rdy_last);
      for (int i = 7; i >= 0; i--) begin
         if (i == 0) ready_i = rdy_last;
         drive_chunk(w[i*4 +: 4], i == 0);
         if (i == 7) begin
            chk("valid_first_chunk", 32'(valid_o), 32'(first_v));
            clr_i = 1'b0;
         end
      end
      chk("word_data", data_o, exp_d);
      chk("word_valid", 32'(valid_o), 32'd1);
      last_cyc = cyc;
   endtask

   initial begin
      int c0;
      reset   = 1'b0;
      data_i  = 4'h0;
      last_i  = 1'b0;
      clr_i   = 1'b0;
      ready_i = 1'b1;
      #2 reset = 1'b1;
      #1;
      chk("rst_data", data_o, 32'h0);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      chk("rst_ovf", 32'(ovf_o), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #4 reset = 1'b0;
      @(posedge clk);
      #1;

      // alignment cycle must not produce a word
      drive_chunk(4'h0, 1'b1);
      chk("align_no_word", 32'(valid_o), 32'd0);
      send_word(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1);
      chk("deadbeef_err", 32'(err_o), 32'd0);

      // back-to-back words, valid one cycle each, 8 cycles apart
      c0 = last_cyc;
      send_word(32'h01234567, 32'h01234567, 1'b0, 1'b1);
      chk("spacing_1", 32'(last_cyc - c0), 32'd8);
      c0 = last_cyc;
      send_word(32'h89ABCDEF, 32'h89ABCDEF, 1'b0, 1'b1);
      chk("spacing_2", 32'(last_cyc - c0), 32'd8);
      chk("b2b_ovf", 32'(ovf_o), 32'd0);

      // early last on the 5th chunk, with clr_i in the same cycle (error wins)
      for (int i = 0; i < 4; i++) drive_chunk(4'h1, 1'b0);
      clr_i = 1'b1;
      drive_chunk(4'h5, 1'b1);
      clr_i = 1'b0;
      chk("early_err", 32'(err_o), 32'd1);
      chk("early_no_valid", 32'(valid_o), 32'd0);
      send_word(32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b1);
      chk("err_sticky", 32'(err_o), 32'd1);

      // clear err, then 8 chunks with no last -> error and back to SYNC
      clr_i = 1'b1;
      drive_chunk(4'h2, 1'b0);
      clr_i = 1'b0;
      chk("err_cleared", 32'(err_o), 32'd0);
      for (int i = 0; i < 7; i++) drive_chunk(4'h3, 1'b0);
      chk("missing_last_err", 32'(err_o), 32'd1);
      chk("missing_last_no_valid", 32'(valid_o), 32'd0);
      // in SYNC this word only realigns on its last chunk
      for (int i = 7; i >= 0; i--) drive_chunk(4'(i + 8), i == 0);
      chk("sync_ignored", 32'(valid_o), 32'd0);

      // back-pressure: first word held, second dropped with overflow
      ready_i = 1'b0;
      send_word(32'hA5A55A5A, 32'hA5A55A5A, 1'b0, 1'b0);
      chk("ovf_before", 32'(ovf_o), 32'd0);
      send_word(32'h0BADCAFE, 32'hA5A55A5A, 1'b1, 1'b0);
      chk("ovf_set", 32'(ovf_o), 32'd1);

      // accept drops valid during next word; clr_i clears ovf
      ready_i = 1'b1;
      clr_i   = 1'b1;
      send_word(32'h600DF00D, 32'h600DF00D, 1'b0, 1'b1);
      chk("ovf_cleared", 32'(ovf_o), 32'd0);

      // acceptance and completion on the same edge: new word loads, valid stays high
      ready_i = 1'b0;
      send_word(32'h7E57AB1E, 32'h7E57AB1E, 1'b1, 1'b1);
      chk("accept_complete_ovf", 32'(ovf_o), 32'd0);

      // reset at chunk 3 between edges
      drive_chunk(4'h9, 1'b0);
      drive_chunk(4'h9, 1'b0);
      drive_chunk(4'h9, 1'b0);
      #3 reset = 1'b1;
      #1;
      chk("midrst_data", data_o, 32'h0);
      chk("midrst_valid", 32'(valid_o), 32'd0);
      chk("midrst_err", 32'(err_o), 32'd0);
      chk("midrst_ovf", 32'(ovf_o), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #4 reset = 1'b0;
      @(posedge clk);
      #1;
      drive_chunk(4'h0, 1'b1);
      chk("realign_no_word", 32'(valid_o), 32'd0);
      send_word(32'h13579BDF, 32'h13579BDF, 1'b0, 1'b1);
      chk("after_rst_err", 32'(err_o), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shift_deserializer.md
SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 SHALL have parameter FROM, default 32, meaning reassembled word width in bits.
REQ-002 SHALL have parameter TO, default 4, meaning serial lane width in bits per cycle; FROM % TO == 0 and N = FROM/TO >= 2 required, else elaboration error.
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port data_i  input  TO  serial chunk, one per clk, most-significant chunk of each word first.
REQ-006 SHALL have port last_i  input  1  high in the cycle data_i carries chunk 0 (least-significant) of a word; connects to the upstream serializer's ready output.
REQ-007 SHALL have port clr_i  input  1  synchronous clear of sticky flags.
REQ-008 SHALL have port data_o  output  FROM  reassembled word.
REQ-009 SHALL have port valid_o  output  1  data_o holds an unconsumed word.
REQ-010 SHALL have port ready_i  input  1  downstream accepts data_o when valid_o && ready_i.
REQ-011 SHALL have port err_o  output  1  sticky framing-error flag.
REQ-012 SHALL have port ovf_o  output  1  sticky overflow flag (word dropped).

Function
REQ-013 SHALL implement FSM with states SYNC and COLLECT, a chunk counter cnt of width max(1,$clog2(N)), and a FROM-TO-bit shift register sr.
REQ-014 In SYNC, data_i SHALL be ignored; last_i=1 -> COLLECT with cnt=0; last_i=0 -> stay SYNC.
REQ-015 In COLLECT with cnt<N-1 and last_i=0: sr <= {sr, data_i} truncated to FROM-TO bits, cnt <= cnt+1.
REQ-016 In COLLECT with cnt==N-1 and last_i=1: word = {sr, data_i} SHALL complete; cnt <= 0; stay COLLECT.
REQ-017 In COLLECT with last_i=1 and cnt!=N-1 (early last): partial word dropped, err_o <= 1, cnt <= 0, stay COLLECT (next cycle starts a new word).
REQ-018 In COLLECT with cnt==N-1 and last_i=0 (missing last): partial word dropped, err_o <= 1, cnt <= 0, state <= SYNC.
REQ-019 On completion, if valid_o==0 or ready_i==1, data_o <= word and valid_o <= 1 on the same edge; valid_o rises one cycle after the chunk-0 cycle.
REQ-020 On completion with valid_o==1 and ready_i==0, the new word SHALL be dropped, data_o unchanged, ovf_o <= 1.
REQ-021 Without completion, valid_o && ready_i SHALL clear valid_o next edge; data_o holds its value.
REQ-022 Throughput SHALL be one word per N cycles with no bubbles when ready_i stays high.
REQ-023 clr_i=1 SHALL clear err_o and ovf_o next edge; a new error/overflow in the same cycle SHALL win (flag stays 1).
REQ-024 Simultaneous acceptance and completion SHALL load the new word with valid_o held at 1.

Reset
REQ-025 While reset=1: state=SYNC, cnt=0, sr=0, data_o=0, valid_o=0, err_o=0, ovf_o=0, independent of clk.
REQ-026 Reset mid-word SHALL discard the partial word; after release the block SHALL wait in SYNC for last_i.
REQ-027 The first last_i after reset (the upstream serializer asserts it with zero data in its first cycle) SHALL only align and SHALL NOT produce a word.

Verification (FROM=32, TO=4, N=8)
REQ-028 Reset, last_i=1 with data 0, then chunks D,E,A,D,B,E,E,F with last_i on F, ready_i=1 -> next cycle data_o=0xDEADBEEF, valid_o=1 for exactly one cycle, err_o=0.
REQ-029 Back-to-back words 0x01234567, 0x89ABCDEF, ready_i=1 -> valid_o pulses 8 cycles apart with matching data, no ovf_o.
REQ-030 After alignment, last_i=1 on the 5th chunk -> err_o=1, no valid_o; the following correct 8-chunk word -> data_o correct.
REQ-031 After alignment, 8 chunks with last_i=0 -> err_o=1, FSM in SYNC; next word is ignored until a last_i arrives, then following word is received correctly.
REQ-032 ready_i=0 while two words complete -> data_o holds first word, ovf_o=1; ready_i=1 -> valid_o drops; clr_i=1 -> ovf_o=0.
REQ-033 reset asserted at chunk 3 between clock edges -> all outputs 0 immediately; after release, stream with leading last_i -> correct word, no err_o.
